mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified memory between the MIPS CPU instruction-fetch
//  requester (IF) and data requester (D, load/store). It arbitrates, sequences
//  each access over a fixed-latency memory, returns read data and pulses an ack.
//  Sits between the CPU core and the memory inside top.
// PARAMETERS
//  AW          32  address width, passed through unchanged
//  DW          32  data width
//  WAIT_CYC    1   memory read latency in cycles after the mem_en cycle (1..15)
//  STARVE_MAX  3   consecutive IF losses before IF is forced to win; 0 = strict D priority
// PORTS
//  ClkIn      in   1   system clock, rising edge
//  Rst        in   1   asynchronous reset, active-low
//  if_req     in   1   IF access request; held until if_ack
//  if_addr    in   AW  IF address; stable while if_req
//  if_ack     out  1   one-cycle pulse: IF access done, if_rdata valid
//  if_rdata   out  DW  IF read data; holds until next IF ack
//  d_req      in   1   D access request; held until d_ack
//  d_we       in   1   1 = store, 0 = load; stable while d_req
//  d_addr     in   AW  D address
//  d_wdata    in   DW  store data
//  d_ack      out  1   one-cycle pulse: D access done (d_rdata valid if load)
//  d_rdata    out  DW  D load data; holds until next D load ack
//  mem_en     out  1   memory access strobe, one cycle per access
//  mem_we     out  1   memory write enable, only with mem_en
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid WAIT_CYC cycles after mem_en
//  busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (Rst=0, async): state IDLE; all outputs, rdata regs, wait counter and
//   starvation counter = 0. Access in flight is abandoned, no ack issued.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
//  IDLE: if any req, choose source, latch addr/we/wdata and source id -> ISSUE.
//   Only D: D. Only IF: IF. Both: D, unless starve_cnt == STARVE_MAX (and
//   STARVE_MAX != 0), then IF.
//  Starvation counter: +1 when both requested and D won; cleared when IF is
//   granted; saturates at STARVE_MAX.
//  ISSUE (1 cycle): mem_en=1, mem_addr/mem_wdata from latch, mem_we=1 only for
//   a D store; wait counter loaded with WAIT_CYC-1 -> WAIT.
//  WAIT: mem_en=0, mem_we=0; counter decrements. When counter == 0: capture
//   mem_rdata into the granted source's rdata reg (not for stores) -> RESP.
//  RESP (1 cycle): ack of the granted source = 1; requests ignored -> IDLE.
//  Latency: req seen in IDLE cycle T -> mem_en at T+1 -> ack at T+WAIT_CYC+2.
//   Back-to-back accesses are separated by one IDLE cycle (RESP drops req).
//  if_ack and d_ack never assert together; at most one mem_en per access.
//  Req dropped mid-access (protocol violation): access still completes and
//   ack pulses; no abort.
//  Store ack: d_rdata unchanged. mem_addr/mem_wdata hold last value when idle.
//  Addresses are not checked for alignment.
// TESTING
//  1. Reset: Rst=0 at t=0, released at 20ns, no reqs -> all outputs 0, busy=0.
//  2. IF alone, WAIT_CYC=1, if_addr=0x00000004, mem returns 0x2108000A ->
//     mem_en at T+1, if_ack at T+3, if_rdata=0x2108000A, d_ack stays 0.
//  3. D store d_addr=0x10, d_wdata=0xDEADBEEF -> one cycle mem_en=mem_we=1 with
//     those values, d_ack at T+3, d_rdata unchanged.
//  4. Both requesting continuously, STARVE_MAX=3 -> grant order D,D,D,IF,D,D,D,IF;
//     STARVE_MAX=0 -> IF never granted while d_req held.
//  5. WAIT_CYC=4, D load -> d_ack exactly 6 cycles after req sampled; d_rdata =
//     mem_rdata of cycle T+5.
//  6. Rst asserted during WAIT -> outputs 0 immediately, no ack; after release
//     a new IF request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified single-port memory. The IF and D requesters
// share one fixed-latency memory. D normally has priority. IF is forced through after
// STARVE_MAX consecutive losses. Each access runs IDLE -> ISSUE -> WAIT -> RESP,
// and every output is driven from a register.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned WAIT_CYC   = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          ClkIn,
  input  logic          Rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // With STARVE_MAX == 0 the counter never moves, but it keeps one bit so it is never zero-width.
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

  state_t        state_q;
  logic          src_if_q;   // granted source: 1 = IF, 0 = D
  logic          store_q;    // granted access is a D store
  logic [3:0]    wait_q;
  logic [SW-1:0] starve_q;
  logic          grant_if;

  // IF wins on its own, or when it has lost to D too many times in a row.
  always_comb begin
    grant_if = 1'b0;
    if (if_req) begin
      grant_if = !d_req || ((STARVE_MAX != 0) && (starve_q == SW'(STARVE_MAX)));
    end
  end

  // Access sequencer. mem_addr and mem_wdata are the latched request and hold their value while idle.
  always_ff @(posedge ClkIn or negedge Rst) begin
    if (!Rst) begin
      state_q   <= StIdle;
      src_if_q  <= 1'b0;
      store_q   <= 1'b0;
      wait_q    <= '0;
      starve_q  <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            src_if_q <= grant_if;
            store_q  <= !grant_if && d_we;
            // The strobe is loaded here so that it is high for exactly the ISSUE cycle.
            mem_en   <= 1'b1;
            mem_we   <= !grant_if && d_we;
            if (grant_if) begin
              mem_addr <= if_addr;
              starve_q <= '0;
            end else begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req && (starve_q != SW'(STARVE_MAX))) begin
                starve_q <= starve_q + SW'(1);
              end
            end
            busy    <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          wait_q  <= 4'(WAIT_CYC - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == 4'd0) begin
            if (src_if_q) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!store_q) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end
            state_q <= StResp;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
